// File: rtl/imem_pkg.sv
`default_nettype none
// ============================================================================
// Module   : imem_pkg
// Purpose  : Shared sizes and response-FIFO count encoding for imem_responder.
// Revision : 1.0
// ============================================================================
package imem_pkg;

    localparam int IMEM_AW         = 5;
    localparam int IMEM_DW         = 32;
    localparam int IMEM_FIFO_DEPTH = 2;

    localparam logic [1:0] CNT_EMPTY = 2'd0;
    localparam logic [1:0] CNT_ONE   = 2'd1;
    localparam logic [1:0] CNT_FULL  = 2'd2;

endpackage
`default_nettype wire

// File: rtl/imem_rsp_fifo.sv
`default_nettype none
// ============================================================================
// Module   : imem_rsp_fifo
// Purpose  : 2-entry response FIFO (data+addr+err) with flush and async reset.
// Revision : 1.0
// ============================================================================
module imem_rsp_fifo
    import imem_pkg::*;
#(
    parameter int AW = IMEM_AW,
    parameter int DW = IMEM_DW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic [DW-1:0] push_data,
    input  logic [AW-1:0] push_addr,
    input  logic          push_err,
    input  logic          pop,
    input  logic          flush,
    output logic          full,
    output logic          head_valid,
    output logic [DW-1:0] head_data,
    output logic [AW-1:0] head_addr,
    output logic          head_err
);

    logic [DW-1:0] data_q [IMEM_FIFO_DEPTH];
    logic [DW-1:0] data_d [IMEM_FIFO_DEPTH];
    logic [AW-1:0] addr_q [IMEM_FIFO_DEPTH];
    logic [AW-1:0] addr_d [IMEM_FIFO_DEPTH];
    logic          err_q  [IMEM_FIFO_DEPTH];
    logic          err_d  [IMEM_FIFO_DEPTH];
    logic          wr_ptr_q, wr_ptr_d;
    logic          rd_ptr_q, rd_ptr_d;
    logic [1:0]    count_q, count_d;
    logic          do_push, do_pop;

    assign do_push = push && (count_q != CNT_FULL);
    assign do_pop  = pop && (count_q != CNT_EMPTY);

    always_comb begin
        data_d   = data_q;
        addr_d   = addr_q;
        err_d    = err_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            data_d[wr_ptr_q] = push_data;
            addr_d[wr_ptr_q] = push_addr;
            err_d[wr_ptr_q]  = push_err;
            wr_ptr_d         = wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({do_push, do_pop})
            2'b10:   count_d = (count_q == CNT_EMPTY) ? CNT_ONE : CNT_FULL;
            2'b01:   count_d = (count_q == CNT_FULL) ? CNT_ONE : CNT_EMPTY;
            default: count_d = count_q;
        endcase
        // Flush wins over everything: a same-cycle pop is simply absorbed.
        if (flush) begin
            count_d  = CNT_EMPTY;
            wr_ptr_d = 1'b0;
            rd_ptr_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_q   <= '{default: '0};
            addr_q   <= '{default: '0};
            err_q    <= '{default: 1'b0};
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= CNT_EMPTY;
        end else begin
            data_q   <= data_d;
            addr_q   <= addr_d;
            err_q    <= err_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign full       = (count_q == CNT_FULL);
    assign head_valid = (count_q != CNT_EMPTY);
    assign head_data  = data_q[rd_ptr_q];
    assign head_addr  = addr_q[rd_ptr_q];
    assign head_err   = err_q[rd_ptr_q];

endmodule
`default_nettype wire

// File: rtl/imem_responder.sv
`default_nettype none
// ============================================================================
// Module   : imem_responder
// Purpose  : Loadable instruction memory answering fetches through a 2-entry
//            response FIFO. Optional word parity under macro IMEM_PARITY_EN.
// Revision : 1.0
// ============================================================================
module imem_responder
    import imem_pkg::*;
#(
    parameter int AW = IMEM_AW,
    parameter int DW = IMEM_DW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic [AW-1:0] req_addr,
    input  logic          flush,
    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic [DW-1:0] rsp_data,
    output logic [AW-1:0] rsp_addr,
    output logic          rsp_err,
    input  logic          load_en,
    input  logic [AW-1:0] load_addr,
    input  logic [DW-1:0] load_data,
    input  logic          load_par_flip
);

    localparam int DEPTH = 2 ** AW;

    logic [DW-1:0] mem_q [DEPTH];
    logic [DW-1:0] mem_d [DEPTH];
    logic          fifo_full;
    logic          push;
    logic [DW-1:0] fetch_word;
    logic          fetch_err;

    always_comb begin
        mem_d = mem_q;
        if (load_en) begin
            mem_d[load_addr] = load_data;
        end
    end

    // Program memory is deliberately not reset; it survives rst and flush.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign req_ready  = !flush && !fifo_full;
    assign push       = req_valid && req_ready;
    assign fetch_word = mem_q[req_addr];

`ifdef IMEM_PARITY_EN
    logic par_q [DEPTH];
    logic par_d [DEPTH];

    always_comb begin
        par_d = par_q;
        if (load_en) begin
            par_d[load_addr] = (^load_data) ^ load_par_flip;
        end
    end

    always_ff @(posedge clk) begin
        par_q <= par_d;
    end

    assign fetch_err = (^fetch_word) != par_q[req_addr];
`else
    logic unused_par_flip;
    assign unused_par_flip = load_par_flip;
    assign fetch_err       = 1'b0;
`endif

    imem_rsp_fifo #(
        .AW (AW),
        .DW (DW)
    ) u_rsp_fifo (
        .clk        (clk),
        .rst        (rst),
        .push       (push),
        .push_data  (fetch_word),
        .push_addr  (req_addr),
        .push_err   (fetch_err),
        .pop        (rsp_valid && rsp_ready),
        .flush      (flush),
        .full       (fifo_full),
        .head_valid (rsp_valid),
        .head_data  (rsp_data),
        .head_addr  (rsp_addr),
        .head_err   (rsp_err)
    );

endmodule
`default_nettype wire

// File: tb/tb_imem_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_imem_responder
// Purpose  : Randomized + directed scoreboard bench for imem_responder.
// Revision : 1.0
// ============================================================================
module tb_imem_responder;

    localparam int AW = 5;
    localparam int DW = 32;
`ifdef IMEM_PARITY_EN
    localparam bit PAR = 1'b1;
`else
    localparam bit PAR = 1'b0;
`endif

    typedef struct {
        logic [DW-1:0] d;
        logic [AW-1:0] a;
        logic          e;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          req_valid, req_ready, flush, rsp_valid, rsp_ready, rsp_err;
    logic          load_en, load_par_flip;
    logic [AW-1:0] req_addr, rsp_addr, load_addr;
    logic [DW-1:0] rsp_data, load_data;

    exp_t          q[$];
    logic [DW-1:0] mem_m  [2**AW];
    logic          flip_m [2**AW];
    int            pre_cnt = 0;
    int            vectors = 0;
    int            miscompares = 0;

    imem_responder #(.AW(AW), .DW(DW)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_addr(req_addr), .flush(flush), .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_addr(rsp_addr),
        .rsp_err(rsp_err), .load_en(load_en), .load_addr(load_addr),
        .load_data(load_data), .load_par_flip(load_par_flip)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // One clock of stimulus; the expected response is queued when the model accepts.
    task automatic cycle(input logic rv, input logic [AW-1:0] ra, input logic rr,
                         input logic fl, input logic le, input logic [AW-1:0] la,
                         input logic [DW-1:0] ld, input logic lf);
        logic exp_rdy;
        @(negedge clk);
        req_valid = rv; req_addr = ra; rsp_ready = rr; flush = fl;
        load_en = le; load_addr = la; load_data = ld; load_par_flip = lf;
        #3;
        exp_rdy = !fl && (pre_cnt != 2);
        check("req_ready", {63'd0, req_ready}, {63'd0, exp_rdy});
        if (rv && exp_rdy) q.push_back('{d: mem_m[ra], a: ra, e: PAR && flip_m[ra]});
        if (le) begin
            mem_m[la]  = ld;
            flip_m[la] = lf;
        end
    endtask

    task automatic idle(input logic rr);
        cycle(1'b0, '0, rr, 1'b0, 1'b0, '0, '0, 1'b0);
    endtask

    task automatic load(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic f);
        cycle(1'b0, '0, 1'b1, 1'b0, 1'b1, a, d, f);
    endtask

    task automatic fetch(input logic [AW-1:0] a, input logic rr);
        cycle(1'b1, a, rr, 1'b0, 1'b0, '0, '0, 1'b0);
    endtask

    // Monitor: compares the FIFO head every cycle, retires it on handshake.
    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (rst) begin
                pre_cnt = 0;
            end else begin
                pre_cnt = q.size();
                check("rsp_valid", {63'd0, rsp_valid}, {63'd0, q.size() != 0});
                if (rsp_valid && q.size() != 0) begin
                    check("rsp_head", {26'd0, rsp_err, rsp_addr, rsp_data},
                          {26'd0, q[0].e, q[0].a, q[0].d});
                    if (rsp_ready) void'(q.pop_front());
                end
                if (flush) q.delete();
            end
        end
    end

    initial begin
        rst = 1'b1;
        req_valid = 0; req_addr = '0; flush = 0; rsp_ready = 0;
        load_en = 0; load_addr = '0; load_data = '0; load_par_flip = 0;
        @(posedge clk);
        #1;
        check("rst_rsp_valid", {63'd0, rsp_valid}, 64'd0);
        check("rst_rsp_data", {32'd0, rsp_data}, 64'd0);
        check("rst_rsp_addr", {59'd0, rsp_addr}, 64'd0);
        check("rst_rsp_err", {63'd0, rsp_err}, 64'd0);
        @(negedge clk);
        #1 rst = 1'b0;

        for (int i = 0; i < 2**AW; i++) load(AW'(i), $urandom, 1'b0);

        // Basic fetch, latency one
        load(5'd3, 32'h00A00093, 1'b0);
        fetch(5'd3, 1'b1);
        idle(1'b1);
        check("basic_data", {32'd0, rsp_data}, 64'h00A00093);
        check("basic_addr", {59'd0, rsp_addr}, 64'd3);

        // Backpressure: third fetch waits for space
        fetch(5'd0, 1'b0);
        fetch(5'd1, 1'b0);
        fetch(5'd2, 1'b0);
        fetch(5'd2, 1'b1);
        fetch(5'd2, 1'b1);
        repeat (3) idle(1'b1);

        // Flush with full FIFO and a request present
        fetch(5'd9, 1'b0);
        fetch(5'd10, 1'b0);
        cycle(1'b1, 5'd11, 1'b0, 1'b1, 1'b0, '0, '0, 1'b0);
        idle(1'b0);
        check("flush_empty", {63'd0, rsp_valid}, 64'd0);

        // Same-edge load and fetch returns the old word
        load(5'd5, 32'h22222222, 1'b0);
        cycle(1'b1, 5'd5, 1'b1, 1'b0, 1'b1, 5'd5, 32'h11111111, 1'b0);
        idle(1'b1);
        check("rw_old", {32'd0, rsp_data}, 64'h22222222);
        fetch(5'd5, 1'b1);
        idle(1'b1);
        check("rw_new", {32'd0, rsp_data}, 64'h11111111);

        // Parity error injection
        load(5'd7, 32'h0F0F1234, 1'b1);
        load(5'd8, 32'h0F0F1235, 1'b0);
        fetch(5'd7, 1'b1);
        idle(1'b1);
        check("par_flip", {63'd0, rsp_err}, {63'd0, PAR});
        fetch(5'd8, 1'b1);
        idle(1'b1);
        check("par_ok", {63'd0, rsp_err}, 64'd0);

        // Asynchronous reset mid-transfer; memory survives
        fetch(5'd3, 1'b0);
        idle(1'b0);
        @(negedge clk);
        req_valid = 0; rsp_ready = 0; load_en = 0; flush = 0;
        #1 rst = 1'b1;
        #1;
        check("async_rst_valid", {63'd0, rsp_valid}, 64'd0);
        check("async_rst_data", {32'd0, rsp_data}, 64'd0);
        q.delete();
        @(negedge clk);
        #1 rst = 1'b0;
        fetch(5'd3, 1'b1);
        idle(1'b1);
        check("mem_kept", {32'd0, rsp_data}, 64'h00A00093);

        // Randomized traffic
        repeat (400) begin
            cycle(1'($urandom_range(0, 1)), AW'($urandom), 1'($urandom_range(0, 3) != 0),
                  1'($urandom_range(0, 19) == 0), 1'($urandom_range(0, 3) == 0),
                  AW'($urandom), $urandom, 1'($urandom_range(0, 7) == 0));
        end
        repeat (4) idle(1'b1);
        check("drain", 64'(q.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/imem_responder.md
IMEM_RESPONDER -- requirements
Module: imem_responder

Interface
REQ-001 Parameter AW, default 5, fetch/load word-address width; memory depth is 2**AW words.
REQ-002 Parameter DW, default 32, instruction word width.
REQ-003 clk  in  1  rising-edge clock for all state.
REQ-004 rst  in  1  reset, asynchronous, active-high.
REQ-005 req_valid  in  1  fetch request present.
REQ-006 req_ready  out  1  request accepted on an edge where req_valid && req_ready.
REQ-007 req_addr  in  AW  word address of the fetch.
REQ-008 flush  in  1  discard all pending responses (jump taken).
REQ-009 rsp_valid  out  1  response present at FIFO head.
REQ-010 rsp_ready  in  1  consumer takes the response on an edge where rsp_valid && rsp_ready.
REQ-011 rsp_data  out  DW  instruction word.
REQ-012 rsp_addr  out  AW  address that produced rsp_data.
REQ-013 rsp_err  out  1  parity error flag for this response.
REQ-014 load_en / load_addr / load_data  in  1/AW/DW  program-load write port.
REQ-015 load_par_flip  in  1  store inverted parity on this load (test hook).

Function
REQ-016 Memory SHALL be 2**AW x DW registers, written on rising edge when load_en=1.
REQ-017 A same-edge load and accepted fetch of the same address SHALL return the pre-write word.
REQ-018 An accepted fetch SHALL be read and pushed into a 2-entry response FIFO on the accept edge; rsp_valid SHALL be 1 in the following cycle (latency 1).
REQ-019 req_ready SHALL equal !flush && (count != 2), with no combinational path from rsp_ready.
REQ-020 Pop SHALL occur on rsp_valid && rsp_ready; push and pop on the same edge SHALL leave count unchanged.
REQ-021 Responses SHALL be returned in acceptance order; rsp_data/rsp_addr/rsp_err SHALL be stable while rsp_valid && !rsp_ready.
REQ-022 Count states SHALL be EMPTY(0), ONE(1), FULL(2); transitions only by push (+1), pop (-1), push+pop (0), flush (to EMPTY).
REQ-023 flush=1 at an edge SHALL set count and both pointers to 0; a handshake in the flush cycle counts as completed; no request is accepted in that cycle.
REQ-024 Pointers SHALL be 1 bit and wrap 1->0.
REQ-025 Memory contents SHALL be unaffected by flush.

Reset
REQ-026 rst=1 SHALL asynchronously force count=0, pointers=0, rsp_valid=0, rsp_data=0, rsp_addr=0, rsp_err=0; req_ready SHALL be 1 while rst=0 and flush=0 after reset.
REQ-027 Memory SHALL NOT be cleared by rst; reset mid-transfer SHALL drop all pending responses.

Configuration
REQ-028 Macro IMEM_PARITY_EN defined: one even-parity bit per word stored on load (inverted when load_par_flip=1), checked on read, rsp_err=1 on mismatch.
REQ-029 Macro IMEM_PARITY_EN undefined: no parity storage, rsp_err tied 0, load_par_flip ignored; ports are identical in both builds.

Structure
REQ-030 Package imem_pkg SHALL hold IMEM_AW=5, IMEM_DW=32, IMEM_FIFO_DEPTH=2 and the count-state encoding.
REQ-031 The 2-entry FIFO SHALL be sub-module imem_rsp_fifo (push/pop/flush, data+addr+err payload); memory and parity stay in imem_responder.

Verification
REQ-032 Load addr 3 = 0x00A00093; fetch 3 with rsp_ready=1 -> next cycle rsp_valid=1, rsp_data=0x00A00093, rsp_addr=3.
REQ-033 rsp_ready=0, fetch 0,1,2 back-to-back -> 0 and 1 accepted, req_ready=0 after second; release -> responses 0 then 1; 2 accepted only after ready returns.
REQ-034 FIFO=2 entries, flush=1 for one cycle with req_valid=1 -> req_ready=0, next cycle rsp_valid=0, count=0.
REQ-035 Same-edge load addr 5 = 0x11111111 (old 0x22222222) and fetch 5 -> rsp_data=0x22222222; refetch -> 0x11111111.
REQ-036 IMEM_PARITY_EN build: load addr 7 with load_par_flip=1, fetch 7 -> rsp_err=1; addr 8 normal -> rsp_err=0; non-parity build -> rsp_err=0 for both.
REQ-037 rst pulse while rsp_valid=1 -> rsp_valid=0 immediately (async), memory word previously loaded still returned on next fetch.
